// File: rtl/imem_read_arbiter.sv
// imem_read_arbiter: two-master, one-burst-outstanding AXI read arbiter, M0 priority with M1 starvation guard
module imem_read_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [3:0]            m0_arlen,
  input  logic [3:0]            m0_arid,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  output logic                  m0_rlast,
  input  logic                  m0_rready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [3:0]            m1_arlen,
  input  logic [3:0]            m1_arid,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic                  m1_rlast,
  input  logic                  m1_rready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [3:0]            s_arlen,
  output logic [3:0]            s_arid,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [3:0]            s_rid,
  input  logic                  s_rvalid,
  input  logic                  s_rlast,
  output logic                  s_rready,
  output logic                  grant,
  output logic                  busy,
  output logic                  id_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t     r_state, w_next;
  logic       r_grant, r_id_err;
  logic [3:0] r_starve, r_arid;
  logic       w_idle, w_addr, w_data, w_req, w_pick_m1, w_beat, w_unused;
  assign w_unused = m0_arid[3] ^ m1_arid[3];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_idle     = r_state == IDLE;
    w_addr     = r_state == ADDR;
    w_data     = r_state == DATA;
    w_req      = m0_arvalid | m1_arvalid;
    w_pick_m1  = m1_arvalid & (~m0_arvalid | (r_starve == LIMIT));
    s_araddr   = r_grant ? m1_araddr : m0_araddr;
    s_arlen    = r_grant ? m1_arlen : m0_arlen;
    s_arid     = r_arid;
    s_arvalid  = w_addr & (r_grant ? m1_arvalid : m0_arvalid);
    m0_arready = w_addr & ~r_grant & s_arready;
    m1_arready = w_addr & r_grant & s_arready;
    s_rready   = w_data & (r_grant ? m1_rready : m0_rready);
    m0_rvalid  = w_data & ~r_grant & s_rvalid;
    m1_rvalid  = w_data & r_grant & s_rvalid;
    m0_rlast   = w_data & ~r_grant & s_rlast;
    m1_rlast   = w_data & r_grant & s_rlast;
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
    w_beat     = s_rvalid & s_rready;
    grant      = r_grant;
    busy       = ~w_idle;
    id_err     = r_id_err;
    w_next     = r_state;
    if (w_idle && w_req)                 w_next = ADDR;
    if (w_addr && s_arvalid && s_arready) w_next = DATA;
    if (w_data && w_beat && s_rlast)     w_next = IDLE;
  end
  // grant, issued ID and starvation count only change at the IDLE decision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_grant  <= 1'b0;
      r_arid   <= 4'd0;
      r_starve <= 4'd0;
      r_id_err <= 1'b0;
    end else begin
      if (w_idle && w_req) begin
        r_grant  <= w_pick_m1;
        r_arid   <= {w_pick_m1, w_pick_m1 ? m1_arid[2:0] : m0_arid[2:0]};
        r_starve <= w_pick_m1 ? 4'd0 : (m1_arvalid && r_starve != LIMIT) ? r_starve + 4'd1 : r_starve;
      end
      if (w_data && w_beat && s_rid != r_arid) r_id_err <= 1'b1;
    end
endmodule

// File: tb/tb_imem_read_arbiter.sv
// tb_imem_read_arbiter: directed scoreboard bench for imem_read_arbiter
module tb_imem_read_arbiter;
  logic        clk = 0, rst = 0;
  logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata, s_araddr, s_rdata;
  logic [3:0]  m0_arlen, m1_arlen, m0_arid, m1_arid, s_arlen, s_arid, s_rid;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid;
  logic        m0_rlast, m1_rlast, m0_rready, m1_rready, s_arvalid, s_arready;
  logic        s_rvalid, s_rlast, s_rready, grant, busy, id_err;
  int          total = 0, bad = 0;
  logic [39:0] q0[$], q1[$];
  logic        g;
  logic [3:0]  id;
  int          w;

  imem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arid(m0_arid), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arid(m1_arid), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
    .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rid(s_rid), .s_rvalid(s_rvalid),
    .s_rlast(s_rlast), .s_rready(s_rready), .grant(grant), .busy(busy), .id_err(id_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // an empty queue yields a value no delivered beat can match
  always @(negedge clk) if (!rst) begin
    if (m0_rvalid && m0_rready)
      chk("m0_beat", {7'd0, m0_rlast, m0_rdata}, q0.size() != 0 ? q0.pop_front() : 40'hFF_FFFF_FFFF);
    if (m1_rvalid && m1_rready)
      chk("m1_beat", {7'd0, m1_rlast, m1_rdata}, q1.size() != 0 ? q1.pop_front() : 40'hFF_FFFF_FFFF);
  end

  // memory + master model for one burst; entered and left at posedge+1
  task automatic serve(input int ar_wait, input bit bad_rid, input bit keep_m0, input bit toggle,
                       input int rst_beat, output logic og, output logic [3:0] oid, output int waited);
    logic [31:0] a;
    logic [3:0]  l;
    logic        rr;
    int          i, cyc;
    waited = 0;
    while (!s_arvalid && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("arvalid_up", 40'(s_arvalid), 40'd1);
    chk("busy_addr", 40'(busy), 40'd1);
    a = s_araddr; l = s_arlen; oid = s_arid; og = grant;
    for (int k = 0; k < ar_wait; k++) begin
      s_arready = 0;
      #1;
      chk("arready_mirror0", 40'(og ? m1_arready : m0_arready), 40'd0);
      chk("araddr_stable", 40'(s_araddr), 40'(a));
      chk("arvalid_stable", 40'(s_arvalid), 40'd1);
      @(posedge clk); #1;
    end
    for (int k = 0; k <= int'(l); k++)
      if (og) q1.push_back({7'd0, k == int'(l), a[15:0], 16'(k)});
      else    q0.push_back({7'd0, k == int'(l), a[15:0], 16'(k)});
    s_arready = 1;
    #1;
    chk("arready_mirror1", 40'(og ? m1_arready : m0_arready), 40'd1);
    chk("arready_other0", 40'(og ? m0_arready : m1_arready), 40'd0);
    @(posedge clk); #1;
    s_arready = 0;
    if (og) m1_arvalid = 0;
    else if (!keep_m0) m0_arvalid = 0;
    i = 0; cyc = 0;
    while (i <= int'(l) && cyc < 100) begin
      s_rvalid = 1;
      s_rdata  = {a[15:0], 16'(i)};
      s_rlast  = (i == int'(l));
      s_rid    = bad_rid ? 4'h3 : oid;
      if (toggle) begin
        rr = (cyc != 1);
        if (og) m1_rready = rr; else m0_rready = rr;
      end
      #1;
      if (i == rst_beat) begin
        rst = 1;
        #1;
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_arvalid", 40'(s_arvalid), 40'd0);
        chk("rst_rready", 40'(s_rready), 40'd0);
        chk("rst_r_outs", 40'({m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}), 40'd0);
        chk("rst_arready", 40'({m0_arready, m1_arready}), 40'd0);
        chk("rst_grant", 40'(grant), 40'd0);
        chk("rst_id_err", 40'(id_err), 40'd0);
        q0.delete(); q1.delete();
        s_rvalid = 0; s_rlast = 0;
        @(posedge clk); #1;
        rst = 0;
        return;
      end
      chk("rready_follow", 40'(s_rready), 40'(og ? m1_rready : m0_rready));
      chk("other_rvalid", 40'(og ? m0_rvalid : m1_rvalid), 40'd0);
      rr = s_rready;
      @(posedge clk); #1;
      if (rr) i++;
      cyc++;
    end
    s_rvalid = 0; s_rlast = 0; m0_rready = 1; m1_rready = 1;
    chk("burst_len", 40'(i), 40'(int'(l) + 1));
    chk("busy_fall", 40'(busy), 40'd0);
  endtask

  initial begin
    {m0_araddr, m1_araddr, m0_arlen, m1_arlen, m0_arid, m1_arid} = '0;
    {m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast} = '0;
    s_rdata = '0; s_rid = '0; m0_rready = 1; m1_rready = 1;
    #1 rst = 1;
    #2;
    chk("reset_busy", 40'(busy), 40'd0);
    chk("reset_grant", 40'(grant), 40'd0);
    chk("reset_id_err", 40'(id_err), 40'd0);
    chk("reset_valids", 40'({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}), 40'd0);
    @(posedge clk); #1;
    rst = 0;
    // M1 alone
    m1_araddr = 32'h0000_1000; m1_arlen = 3; m1_arid = 2; m1_arvalid = 1;
    #1;
    chk("t1_idle_arvalid", 40'(s_arvalid), 40'd0);
    @(posedge clk); #1;
    chk("t1_arvalid_next", 40'(s_arvalid), 40'd1);
    chk("t1_arid", 40'(s_arid), 40'hA);
    serve(0, 0, 0, 0, -1, g, id, w);
    chk("t1_grant", 40'(g), 40'd1);
    chk("t1_q1_drained", 40'(q1.size()), 40'd0);
    // simultaneous requests
    m0_araddr = 32'h2000; m0_arlen = 1; m0_arid = 5; m0_arvalid = 1;
    m1_araddr = 32'h3000; m1_arlen = 2; m1_arid = 1; m1_arvalid = 1;
    serve(0, 0, 0, 0, -1, g, id, w);
    chk("t2_first_grant", 40'(g), 40'd0);
    chk("t2_first_id", 40'(id), 40'h5);
    serve(0, 0, 0, 0, -1, g, id, w);
    chk("t2_second_gap", 40'(w), 40'd1);
    chk("t2_second_grant", 40'(g), 40'd1);
    chk("t2_second_id", 40'(id), 40'h9);
    // M0 hogging, M1 waiting
    m0_araddr = 32'h4000; m0_arlen = 0; m0_arid = 1; m0_arvalid = 1;
    m1_araddr = 32'h5000; m1_arlen = 0; m1_arid = 7; m1_arvalid = 1;
    for (int n = 0; n < 5; n++) begin
      serve(0, 0, 1, 0, -1, g, id, w);
      chk("t3_grant_seq", 40'(g), 40'(n == 4));
    end
    chk("t3_starve_clear", 40'(dut.r_starve), 40'd0);
    chk("t3_m1_id", 40'(id), 40'hF);
    serve(0, 0, 0, 0, -1, g, id, w);
    chk("t3_m0_after", 40'(g), 40'd0);
    // address stall
    m0_araddr = 32'h6000; m0_arlen = 1; m0_arid = 3; m0_arvalid = 1;
    serve(5, 0, 0, 0, -1, g, id, w);
    chk("t4_grant", 40'(g), 40'd0);
    // rready back-pressure
    chk("t5_id_err_clean", 40'(id_err), 40'd0);
    m1_araddr = 32'h7000; m1_arlen = 2; m1_arid = 4; m1_arvalid = 1;
    serve(0, 0, 0, 1, -1, g, id, w);
    chk("t5_grant", 40'(g), 40'd1);
    chk("t5_q1_drained", 40'(q1.size()), 40'd0);
    // bad returned ID
    m1_araddr = 32'h0000_1000; m1_arlen = 3; m1_arid = 2; m1_arvalid = 1;
    serve(0, 1, 0, 0, -1, g, id, w);
    chk("t6_id", 40'(id), 40'hA);
    chk("t6_id_err_set", 40'(id_err), 40'd1);
    m0_araddr = 32'h8000; m0_arlen = 0; m0_arid = 0; m0_arvalid = 1;
    serve(0, 0, 0, 0, -1, g, id, w);
    chk("t6_id_err_sticky", 40'(id_err), 40'd1);
    // reset mid-burst, then a fresh request
    m0_araddr = 32'h9000; m0_arlen = 3; m0_arid = 6; m0_arvalid = 1;
    serve(0, 0, 0, 0, 1, g, id, w);
    m0_araddr = 32'hA000; m0_arlen = 1; m0_arid = 1; m0_arvalid = 1;
    serve(0, 0, 0, 0, -1, g, id, w);
    chk("t7_grant", 40'(g), 40'd0);
    chk("t7_id", 40'(id), 40'h1);
    chk("end_q0_empty", 40'(q0.size()), 40'd0);
    chk("end_q1_empty", 40'(q1.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
